// File: rtl/alu_issue_ctrl.sv
// Issue control for a single-cycle scalar ALU plus a vector side port, with a register scoreboard.
// Scalar ops issue at most every other cycle (result/branch cycle follows issue); the head is held off on RAW hazards.
module alu_issue_ctrl #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iq_valid,
  output logic        iq_ready,
  input  logic        iq_is_vec,
  input  logic [5:0]  iq_name,
  input  logic [4:0]  iq_rd,
  input  logic [4:0]  iq_rs1,
  input  logic [4:0]  iq_rs2,
  input  logic        iq_use_rs2,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic        alu_issue,
  output logic [5:0]  alu_name,
  input  logic [31:0] alu_val,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        mem_done,
  input  logic [4:0]  mem_rd,
  output logic        br_valid,
  output logic        br_taken,
  input  logic        flush
);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_LUI   = 6'd2;
  localparam logic [5:0] OP_AUIPC = 6'd3;
  localparam logic [5:0] OP_JAL   = 6'd4;
  localparam logic [5:0] OP_JALR  = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_BEQ   = 6'd8;

  typedef enum logic [1:0] {RUN, WB, BR} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [NREG-1:0]   lw_q, lw_d;
  logic [4:0]        rd_q;
  logic              xfer_scalar;
  logic              hazard;
  logic [NREG-1:0]   set_v, wb_clr, mem_clr, keep_v;

  function automatic logic writes_rd(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LW: writes_rd = 1'b1;
      default:                                                  writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic [NREG-1:0] dec(input logic [4:0] idx);
    for (int i = 0; i < NREG; i++)
      dec[i] = (int'(idx) == i);
  endfunction

  assign rf_rs1_addr = iq_rs1;
  assign rf_rs2_addr = iq_rs2;

  // Registered busy bits only: a clear landing this cycle is not bypassed.
  assign hazard = |(busy_q & dec(iq_rs1)) || (iq_use_rs2 && |(busy_q & dec(iq_rs2)));

  always_comb begin
    state_d     = state_q;
    iq_ready    = 1'b0;
    vec_valid   = 1'b0;
    wb_en       = 1'b0;
    br_valid    = 1'b0;
    xfer_scalar = 1'b0;
    wb_rd       = rd_q;
    wb_data     = alu_val;
    br_taken    = alu_val[0];
    if (!rst && rdy) begin
      if (flush) begin
        state_d = RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (iq_is_vec) begin
              vec_valid = iq_valid;
              iq_ready  = vec_ready;
            end else begin
              iq_ready    = iq_valid && !hazard;
              xfer_scalar = iq_valid && !hazard;
              if (xfer_scalar)
                state_d = (iq_name == OP_BEQ) ? BR : WB;
            end
          end
          WB: begin
            // LW produces only an address here; its rd clears on mem_done.
            wb_en   = writes_rd(alu_name) && (alu_name != OP_LW) && (rd_q != 5'd0);
            state_d = RUN;
          end
          BR: begin
            br_valid = 1'b1;
            state_d  = RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_comb begin
    set_v   = (xfer_scalar && writes_rd(iq_name) && iq_rd != 5'd0) ? dec(iq_rd) : '0;
    wb_clr  = wb_en ? dec(rd_q) : '0;
    mem_clr = mem_done ? dec(mem_rd) : '0;
    keep_v  = flush ? lw_q : '1;
    // Sets are OR'd in last so a same-cycle set beats any clear.
    busy_d    = (busy_q & keep_v & ~wb_clr & ~mem_clr) | set_v;
    busy_d[0] = 1'b0;
    lw_d      = (lw_q & ~mem_clr & ~set_v) | ((iq_name == OP_LW) ? set_v : '0);
    lw_d[0]   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      busy_q    <= '0;
      lw_q      <= '0;
      alu_issue <= 1'b0;
      alu_name  <= 6'd0;
      rd_q      <= 5'd0;
    end else if (rdy) begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      lw_q      <= lw_d;
      alu_issue <= xfer_scalar;
      if (xfer_scalar) begin
        alu_name <= iq_name;
        rd_q     <= iq_rd;
      end
    end
  end

endmodule
